// File: rtl/mixer_ctrl.sv
// mixer_ctrl: user-input controller for the RGB mixer.
// Encoder detents step the selected 8-bit level with saturation, a short
// button press cycles the selected channel R->G->B->R, and a long press
// clears all levels and emits a one-cycle 'cleared' pulse.
module mixer_ctrl #(
  parameter int unsigned STEP        = 1,
  parameter int unsigned LONG_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  output logic [7:0] level_r,
  output logic [7:0] level_g,
  output logic [7:0] level_b,
  output logic [1:0] sel,
  output logic       cleared
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [8:0]  STEP9     = 9'(STEP);
  localparam logic [15:0] HOLD_LAST = 16'(LONG_CYCLES - 1);

  state_t      state_q;
  logic [15:0] hcnt_q;
  logic        prev_a_q;
  logic [7:0]  level_r_q, level_g_q, level_b_q;
  logic [7:0]  level_r_d, level_g_d, level_b_d;
  logic [1:0]  sel_q;
  logic [1:0]  sel_adv_s;
  logic        cleared_q;
  logic        detent_s;

  // Saturating 9-bit step of one level: up clamps at 255, down clamps at 0.
  function automatic logic [7:0] step_level(input logic [7:0] lvl, input logic up);
    logic [8:0] sum;
    if (up) begin
      sum = {1'b0, lvl} + STEP9;
      if (sum > 9'd255) begin
        return 8'hFF;
      end else begin
        return sum[7:0];
      end
    end else begin
      if ({1'b0, lvl} < STEP9) begin
        return 8'd0;
      end else begin
        sum = {1'b0, lvl} - STEP9;
        return sum[7:0];
      end
    end
  endfunction

  assign detent_s = enc_a & ~prev_a_q;

  // Next channel on a short press: R->G->B->R.
  always_comb begin
    sel_adv_s = 2'd0;
    case (sel_q)
      2'd0:    sel_adv_s = 2'd1;
      2'd1:    sel_adv_s = 2'd2;
      default: sel_adv_s = 2'd0;
    endcase
  end

  // Detent applied to the currently selected level; other levels hold.
  always_comb begin
    level_r_d = level_r_q;
    level_g_d = level_g_q;
    level_b_d = level_b_q;
    if (detent_s) begin
      case (sel_q)
        2'd0:    level_r_d = step_level(level_r_q, ~enc_b);
        2'd1:    level_g_d = step_level(level_g_q, ~enc_b);
        2'd2:    level_b_d = step_level(level_b_q, ~enc_b);
        default: level_r_d = level_r_q;
      endcase
    end else begin
      level_r_d = level_r_q;
    end
  end

  // Button FSM plus level/selection registers; a clear overrides any detent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_REL;
      hcnt_q    <= 16'd0;
      prev_a_q  <= enc_a;
      level_r_q <= 8'd0;
      level_g_q <= 8'd0;
      level_b_q <= 8'd0;
      sel_q     <= 2'd0;
      cleared_q <= 1'b0;
    end else begin
      prev_a_q  <= enc_a;
      cleared_q <= 1'b0;
      level_r_q <= level_r_d;
      level_g_q <= level_g_d;
      level_b_q <= level_b_d;
      case (state_q)
        IDLE: begin
          if (btn) begin
            state_q <= PRESS;
            hcnt_q  <= 16'd1;
          end
        end
        PRESS: begin
          if (!btn) begin
            state_q <= IDLE;
            sel_q   <= sel_adv_s;
          end else if (hcnt_q == HOLD_LAST) begin
            state_q   <= WAIT_REL;
            level_r_q <= 8'd0;
            level_g_q <= 8'd0;
            level_b_q <= 8'd0;
            sel_q     <= 2'd0;
            cleared_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 16'd1;
          end
        end
        WAIT_REL: begin
          if (!btn) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= WAIT_REL;
        end
      endcase
    end
  end

  assign level_r = level_r_q;
  assign level_g = level_g_q;
  assign level_b = level_b_q;
  assign sel     = sel_q;
  assign cleared = cleared_q;

endmodule

// File: tb/tb_mixer_ctrl.sv
// Testbench for mixer_ctrl: a per-cycle vector table for the STEP=1 instance
// plus a hand-written saturation sequence for a STEP=100 instance.
module tb_mixer_ctrl;

  logic clk = 1'b0;
  logic reset, enc_a, enc_b, btn;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic [1:0] s1, s2;
  logic c1, c2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, a, b, bt;
    logic [26:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [26:0] expq[$];

  always #5 clk = ~clk;

  mixer_ctrl #(.STEP(1), .LONG_CYCLES(10)) dut1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
    .level_r(r1), .level_g(g1), .level_b(b1), .sel(s1), .cleared(c1));

  mixer_ctrl #(.STEP(100), .LONG_CYCLES(10)) dut2 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
    .level_r(r2), .level_g(g2), .level_b(b2), .sel(s2), .cleared(c2));

  function automatic void v(input int n, input logic rst, input logic a,
                            input logic b, input logic bt, input logic [7:0] er,
                            input logic [7:0] eg, input logic [7:0] eb,
                            input logic [1:0] es, input logic ec);
    vec_t t;
    t.rst = rst; t.a = a; t.b = b; t.bt = bt;
    t.exp = {er, eg, eb, es, ec};
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endfunction

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic step(input string nm, input int idx, input logic rst,
                      input logic a, input logic b, input logic bt,
                      input logic [26:0] exp, input bit use2);
    logic [26:0] got, want;
    @(negedge clk);
    reset = rst; enc_a = a; enc_b = b; btn = bt;
    expq.push_back(exp);
    @(posedge clk);
    #1;
    got  = use2 ? {r2, g2, b2, s2, c2} : {r1, g1, b1, s1, c1};
    want = expq.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got r=%0d g=%0d b=%0d sel=%0d clr=%0d, want r=%0d g=%0d b=%0d sel=%0d clr=%0d",
               nm, idx, got[26:19], got[18:11], got[10:3], got[2:1], got[0],
               want[26:19], want[18:11], want[10:3], want[2:1], want[0]);
    end
  endtask

  function automatic logic [26:0] e(input logic [7:0] er, input logic [7:0] eg,
                                    input logic [7:0] eb, input logic [1:0] es,
                                    input logic ec);
    return {er, eg, eb, es, ec};
  endfunction

  initial begin
    reset = 1'b1; enc_a = 1'b1; enc_b = 1'b0; btn = 1'b1;

    // reset with enc_a and btn high, hold btn, then release: nothing happens
    v(2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(12, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    // 3 increments on R
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 2'd0, 1'b0);
    // 5 decrements on R, saturating at 0
    v(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    // enc_b edge with enc_a steady high is ignored
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    // short press whose release coincides with a detent: old sel gets it
    v(5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd1, 1'b0);
    // 3 increments on G
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd3, 8'd0, 2'd1, 1'b0);
    // short press -> B, one increment on B
    v(5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3, 8'd0, 2'd1, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd3, 8'd0, 2'd2, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd3, 8'd1, 2'd2, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd3, 8'd1, 2'd2, 1'b0);
    // short press -> R, short press -> G
    v(5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3, 8'd1, 2'd2, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd3, 8'd1, 2'd0, 1'b0);
    v(5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3, 8'd1, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd3, 8'd1, 2'd1, 1'b0);
    // long press (10 held edges) with a detent inside and one on the clear edge
    v(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3, 8'd1, 2'd1, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd4, 8'd1, 2'd1, 1'b0);
    v(7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd4, 8'd1, 2'd1, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1);
    // keep holding: pulse does not repeat; release: sel stays 0
    v(3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    // reset in the middle of a press
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    // a fresh short press afterwards works normally
    v(3, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
    v(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step("vec", i, vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].bt, vecs[i].exp, 1'b0);
    end

    // STEP=100 instance: select G, saturate up at 255, then step down
    step("s100", 0, 1'b1, 1'b0, 1'b0, 1'b0, e(8'd0, 8'd0, 8'd0, 2'd0, 1'b0), 1'b1);
    step("s100", 1, 1'b0, 1'b0, 1'b0, 1'b0, e(8'd0, 8'd0, 8'd0, 2'd0, 1'b0), 1'b1);
    step("s100", 2, 1'b0, 1'b0, 1'b0, 1'b1, e(8'd0, 8'd0, 8'd0, 2'd0, 1'b0), 1'b1);
    step("s100", 3, 1'b0, 1'b0, 1'b0, 1'b1, e(8'd0, 8'd0, 8'd0, 2'd0, 1'b0), 1'b1);
    step("s100", 4, 1'b0, 1'b0, 1'b0, 1'b0, e(8'd0, 8'd0, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 5, 1'b0, 1'b1, 1'b0, 1'b0, e(8'd0, 8'd100, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 6, 1'b0, 1'b0, 1'b0, 1'b0, e(8'd0, 8'd100, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 7, 1'b0, 1'b1, 1'b0, 1'b0, e(8'd0, 8'd200, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 8, 1'b0, 1'b0, 1'b0, 1'b0, e(8'd0, 8'd200, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 9, 1'b0, 1'b1, 1'b0, 1'b0, e(8'd0, 8'd255, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 10, 1'b0, 1'b0, 1'b1, 1'b0, e(8'd0, 8'd255, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 11, 1'b0, 1'b1, 1'b1, 1'b0, e(8'd0, 8'd155, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 12, 1'b0, 1'b0, 1'b1, 1'b0, e(8'd0, 8'd155, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 13, 1'b0, 1'b1, 1'b1, 1'b0, e(8'd0, 8'd55, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 14, 1'b0, 1'b0, 1'b1, 1'b0, e(8'd0, 8'd55, 8'd0, 2'd1, 1'b0), 1'b1);
    step("s100", 15, 1'b0, 1'b1, 1'b1, 1'b0, e(8'd0, 8'd0, 8'd0, 2'd1, 1'b0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mixer_ctrl.md
# mixer_ctrl

User-input controller for the RGB mixer. Consumes the debounced quadrature encoder (`enc_a`/`enc_b`) and the debounced push button (`btn`), and maintains three 8-bit channel levels that feed the PWM stage. A short press cycles the edited channel R→G→B→R. A long press clears all levels. Encoder detents step the selected level up or down with saturation.

## Interface
- `STEP`, default 1: level increment/decrement per detent, 1..255.
- `LONG_CYCLES`, default 1000: clocks `btn` must be held for a long press, 2..65535.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enc_a`, in, 1: debounced encoder phase A, synchronous to `clk`.
- `enc_b`, in, 1: debounced encoder phase B, synchronous to `clk`.
- `btn`, in, 1: debounced push button, active-high, synchronous to `clk`.
- `level_r`, out, 8: red level.
- `level_g`, out, 8: green level.
- `level_b`, out, 8: blue level.
- `sel`, out, 2: selected channel; 0=R, 1=G, 2=B. Value 3 never driven.
- `cleared`, out, 1: one-cycle pulse when a long press clears the levels.

## Operation
**Reset values**
- `level_r` = `level_g` = `level_b` = 0, `sel` = 0, `cleared` = 0.
- `prev_a` <= `enc_a`, so no spurious detent after reset.
- FSM <= WAIT_REL, so a button held through reset is ignored.

**Encoder**
- Detent = rising edge of `enc_a` (`enc_a`=1, `prev_a`=0).
- `enc_b`=0 at that edge: increment the selected level. `enc_b`=1: decrement it.
- Falling edges of `enc_a` and all edges of `enc_b` are ignored.
- Arithmetic is 9-bit: increment gives min(level+STEP, 255); decrement gives max(level−STEP, 0). Never wraps.
- Unselected levels hold.

**Button FSM**
- Hold counter `hcnt` is 16-bit.
- IDLE: `btn`=1 → PRESS, `hcnt`<=1.
- PRESS: `btn`=0 → IDLE; `sel` advances 0→1→2→0 (short press, acted on release).
- PRESS: `btn`=1 and `hcnt`==LONG_CYCLES−1 → WAIT_REL. All levels <=0, `sel`<=0, `cleared`<=1 for one cycle.
- PRESS: otherwise `hcnt` increments.
- WAIT_REL: `btn`=0 → IDLE. No `sel` change on this release.

**Simultaneous events**
- Clear and detent on the same edge: clear wins; all levels end at 0.
- `sel` advance and detent on the same edge: the detent applies to the old `sel`.
- Detents during PRESS/WAIT_REL are applied normally, until the clear edge.
- `reset` asserted mid-press: FSM → WAIT_REL, `hcnt` discarded, no `sel` advance on the subsequent release.

## Timing
- All outputs are registered. An input change sampled at edge k is reflected in outputs immediately after edge k (1-cycle latency).
- Long press: `btn` rises before edge p → `cleared` high during the cycle after edge p+LONG_CYCLES−1 (edge p enters PRESS).
- `cleared` is exactly one cycle wide and fires once per press.
- Short press of N cycles (N < LONG_CYCLES) → `sel` changes after the edge that samples `btn`=0.
- Maximum detent rate is one per 2 clocks; every qualifying edge is counted.

## Test plan
- Reset with `enc_a`=1, `btn`=1, then release `btn` → no level change, `sel` stays 0, `cleared` stays 0.
- `sel`=0, 3 detents with `enc_b`=0, STEP=1 → `level_r`=3, `level_g`=`level_b`=0. Then 5 detents with `enc_b`=1 → `level_r`=0 (saturated).
- STEP=100: 3 increments on `sel`=1 → `level_g`=255. 1 decrement → 155.
- Press 5 cycles three times with LONG_CYCLES=10 → `sel` sequence 1, 2, 0. Then hold 10 cycles → `cleared` pulse 1 cycle after the 10th held edge, all levels 0, `sel`=0. Release → `sel` stays 0.
- Detent coincident with the clear edge, levels 50/60/70 → all levels 0. Detent coincident with short-press release at `sel`=0 → `level_r`+1 and `sel`=1.
- Assert `reset` at `hcnt`=5 with `btn` held, deassert, release `btn` → `sel`=0, no `cleared`.
